// File: rtl/wrram_ad_capture_pkg.sv
// Shared definitions for the AD capture and ROM playback paths.
package wrram_ad_capture_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } state_e;

endpackage

// File: rtl/wrram_ad_capture_ram_ad_data.sv
// Simple dual-port RAM: write port A, registered read-first read port B.
module ram_ad_data #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update makes a same-address read return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/wrram_ad_capture.sv
// Captures one decimated record of AD samples into RAM after a start pulse.
module wrram_ad_capture
  import wrram_ad_capture_pkg::*;
#(
  parameter logic [7:0]  DECIM  = 8'd0,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt
);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        dec_cnt_q;
  logic [ADDR_W:0]   sample_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en;

  assign wr_en = (state_q == StCapture) && ad_valid && (dec_cnt_q == DECIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      dec_cnt_q    <= '0;
      sample_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StCapture;
            wr_addr_q    <= '0;
            dec_cnt_q    <= '0;
            sample_cnt_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        StCapture: begin
          if (ad_valid) begin
            if (dec_cnt_q == DECIM) begin
              wr_addr_q    <= wr_addr_q + ADDR_W'(1);
              sample_cnt_q <= sample_cnt_q + (ADDR_W + 1)'(1);
              dec_cnt_q    <= '0;
              // Writing the top address closes the record; wr_addr wraps to 0.
              if (wr_addr_q == '1) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              dec_cnt_q <= dec_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;

  ram_ad_data #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_data (ad_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wrram_ad_capture.sv
// Randomized bench for wrram_ad_capture with DECIM=0 and DECIM=3 instances.
module tb_wrram_ad_capture;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic        ad_valid = 1'b0;
  logic [31:0] ad_data = '0;
  logic [9:0]  rd_addr = '0;

  logic [31:0] rd_data0, rd_data3;
  logic        busy0, busy3, done0, done3;
  logic [10:0] cnt0, cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, one slot per instance (0: DECIM=0, 1: DECIM=3)
  logic        m_busy [2];
  logic        m_done [2];
  int          m_cnt  [2];
  int          m_vcnt [2];
  logic [31:0] exp_mem [2][N];
  bit          written [2][N];
  logic [31:0] exp_rd [2];
  bit          rd_known [2];

  always #5 clk = ~clk;

  wrram_ad_capture #(.DECIM(8'd0), .ADDR_W(10), .DATA_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_data(ad_data), .ad_valid(ad_valid),
    .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .done(done0), .sample_cnt(cnt0)
  );

  wrram_ad_capture #(.DECIM(8'd3), .ADDR_W(10), .DATA_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ad_data(ad_data), .ad_valid(ad_valid),
    .rd_addr(rd_addr), .rd_data(rd_data3), .busy(busy3), .done(done3), .sample_cnt(cnt3)
  );

  function automatic logic [12:0] exp_stat(input int i);
    return {m_busy[i], m_done[i], 11'(m_cnt[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0; m_vcnt[i] = 0;
      exp_rd[i] = '0; rd_known[i] = 1'b1;
    end
  endtask

  // One clock edge as seen by the spec: every D+1-th valid sample is kept.
  task automatic model_edge(input int i, input logic st, input logic v, input logic [31:0] d);
    int dec = (i == 0) ? 0 : 3;
    rd_known[i] = written[i][rd_addr];
    exp_rd[i]   = exp_mem[i][rd_addr];
    if (m_busy[i]) begin
      if (v) begin
        if (m_vcnt[i] % (dec + 1) == dec) begin
          exp_mem[i][m_cnt[i]] = d;
          written[i][m_cnt[i]] = 1'b1;
          m_cnt[i]++;
          if (m_cnt[i] == N) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
        m_vcnt[i]++;
      end
    end else if (st) begin
      m_busy[i] = 1'b1; m_done[i] = 1'b0; m_cnt[i] = 0; m_vcnt[i] = 0;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic st0, input logic st3, input logic v);
    start = st0; start3 = st3; ad_valid = v; ad_data = $urandom;
    @(posedge clk);
    model_edge(0, st0, v, ad_data);
    model_edge(1, st3, v, ad_data);
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
  endtask

  function automatic logic [9:0] pick_addr(input int i);
    return ($urandom_range(1, 0) == 1) ? 10'(m_cnt[i]) : 10'($urandom);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({busy0, done0, cnt0} !== 13'd0) begin
      n_fail++; $display("FAIL reset_status0 got %b want 0", {busy0, done0, cnt0});
    end
    n_tests++;
    if ({busy3, done3, cnt3} !== 13'd0) begin
      n_fail++; $display("FAIL reset_status3 got %b want 0", {busy3, done3, cnt3});
    end
    n_tests++;
    if (rd_data0 !== 32'd0) begin n_fail++; $display("FAIL reset_rd0 got %h want 0", rd_data0); end
    n_tests++;
    if (rd_data3 !== 32'd0) begin n_fail++; $display("FAIL reset_rd3 got %h want 0", rd_data3); end
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    int busy_cycles = 0;
    int guard = 0;
    logic [9:0] addrs [3] = '{10'd0, 10'd511, 10'd1023};
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    while (m_busy[0] && guard < 1100) begin
      if (busy0) busy_cycles++;
      rd_addr = pick_addr(0);
      step(1'b0, 1'b0, 1'b1);
      guard++;
      n_tests++;
      if ({busy0, done0, cnt0} !== exp_stat(0)) begin
        n_fail++; $display("FAIL cont_status got %b want %b", {busy0, done0, cnt0}, exp_stat(0));
      end
      if (rd_known[0]) begin
        n_tests++;
        if (rd_data0 !== exp_rd[0]) begin
          n_fail++; $display("FAIL cont_rd addr %0d got %h want %h", rd_addr, rd_data0, exp_rd[0]);
        end
      end
    end
    n_tests++;
    if (busy_cycles != 1024) begin
      n_fail++; $display("FAIL cont_busy_len got %0d want 1024", busy_cycles);
    end
    n_tests++;
    if (done0 !== 1'b1 || cnt0 !== 11'd1024) begin
      n_fail++; $display("FAIL cont_done got done=%b cnt=%0d want 1/1024", done0, cnt0);
    end
    foreach (addrs[k]) begin
      rd_addr = addrs[k];
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (rd_data0 !== exp_mem[0][addrs[k]]) begin
        n_fail++;
        $display("FAIL cont_read addr %0d got %h want %h", addrs[k], rd_data0, exp_mem[0][addrs[k]]);
      end
    end
  endtask

  task automatic test_decim3();
    int busy_cycles = 0;
    int guard = 0;
    step(1'b0, 1'b1, 1'b1);
    while (m_busy[1] && guard < 4200) begin
      if (busy3) busy_cycles++;
      rd_addr = pick_addr(1);
      step(1'b0, 1'b0, 1'b1);
      guard++;
      n_tests++;
      if ({busy3, done3, cnt3} !== exp_stat(1)) begin
        n_fail++; $display("FAIL dec3_status got %b want %b", {busy3, done3, cnt3}, exp_stat(1));
      end
      if (rd_known[1]) begin
        n_tests++;
        if (rd_data3 !== exp_rd[1]) begin
          n_fail++; $display("FAIL dec3_rd addr %0d got %h want %h", rd_addr, rd_data3, exp_rd[1]);
        end
      end
    end
    n_tests++;
    if (busy_cycles != 4096) begin
      n_fail++; $display("FAIL dec3_busy_len got %0d want 4096", busy_cycles);
    end
    rd_addr = 10'd10;
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rd_data3 !== exp_mem[1][10]) begin
      n_fail++; $display("FAIL dec3_read10 got %h want %h", rd_data3, exp_mem[1][10]);
    end
  endtask

  task automatic test_toggle();
    int busy_cycles = 0;
    int guard = 0;
    step(1'b1, 1'b0, 1'b0);
    while (m_busy[0] && guard < 2200) begin
      if (busy0) busy_cycles++;
      rd_addr = pick_addr(0);
      step(1'b0, 1'b0, guard[0]);
      guard++;
      n_tests++;
      if ({busy0, done0, cnt0} !== exp_stat(0)) begin
        n_fail++; $display("FAIL tog_status got %b want %b", {busy0, done0, cnt0}, exp_stat(0));
      end
      if (rd_known[0]) begin
        n_tests++;
        if (rd_data0 !== exp_rd[0]) begin
          n_fail++; $display("FAIL tog_rd addr %0d got %h want %h", rd_addr, rd_data0, exp_rd[0]);
        end
      end
    end
    n_tests++;
    if (busy_cycles != 2048) begin
      n_fail++; $display("FAIL tog_busy_len got %0d want 2048", busy_cycles);
    end
  endtask

  task automatic test_start_ignored();
    int busy_cycles = 0;
    int guard = 0;
    step(1'b1, 1'b0, 1'b1);
    while (m_busy[0] && guard < 1100) begin
      if (busy0) busy_cycles++;
      rd_addr = pick_addr(0);
      step(m_cnt[0] == 100, 1'b0, 1'b1);
      guard++;
      n_tests++;
      if ({busy0, done0, cnt0} !== exp_stat(0)) begin
        n_fail++; $display("FAIL ign_status got %b want %b", {busy0, done0, cnt0}, exp_stat(0));
      end
      if (rd_known[0]) begin
        n_tests++;
        if (rd_data0 !== exp_rd[0]) begin
          n_fail++; $display("FAIL ign_rd addr %0d got %h want %h", rd_addr, rd_data0, exp_rd[0]);
        end
      end
    end
    n_tests++;
    if (busy_cycles != 1024) begin
      n_fail++; $display("FAIL ign_busy_len got %0d want 1024", busy_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    step(1'b1, 1'b0, 1'b1);
    while (m_cnt[0] < 300 && guard < 400) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({busy0, done0, cnt0, rd_data0} !== 45'd0) begin
      n_fail++; $display("FAIL midrst_out0 got %b/%b/%0d/%h want zeros", busy0, done0, cnt0, rd_data0);
    end
    n_tests++;
    if ({busy3, done3, cnt3, rd_data3} !== 45'd0) begin
      n_fail++; $display("FAIL midrst_out3 got %b/%b/%0d/%h want zeros", busy3, done3, cnt3, rd_data3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_busy[0] && guard < 1100) begin
      rd_addr = pick_addr(0);
      step(1'b0, 1'b0, 1'b1);
      guard++;
      n_tests++;
      if ({busy0, done0, cnt0} !== exp_stat(0)) begin
        n_fail++; $display("FAIL midrst_status got %b want %b", {busy0, done0, cnt0}, exp_stat(0));
      end
    end
    rd_addr = 10'd0;
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rd_data0 !== exp_mem[0][0]) begin
      n_fail++; $display("FAIL midrst_addr0 got %h want %h", rd_data0, exp_mem[0][0]);
    end
  endtask

  task automatic test_restart();
    int guard = 0;
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || cnt0 !== 11'd0) begin
      n_fail++; $display("FAIL restart_entry got b=%b d=%b cnt=%0d want 1/0/0", busy0, done0, cnt0);
    end
    // A start coinciding with the final write must not restart the record.
    while (m_busy[0] && guard < 1100) begin
      rd_addr = pick_addr(0);
      step(m_cnt[0] == N - 1, 1'b0, 1'b1);
      guard++;
      n_tests++;
      if ({busy0, done0, cnt0} !== exp_stat(0)) begin
        n_fail++; $display("FAIL restart_status got %b want %b", {busy0, done0, cnt0}, exp_stat(0));
      end
      if (rd_known[0]) begin
        n_tests++;
        if (rd_data0 !== exp_rd[0]) begin
          n_fail++; $display("FAIL restart_rd addr %0d got %h want %h", rd_addr, rd_data0, exp_rd[0]);
        end
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({busy0, done0, cnt0} !== {1'b0, 1'b1, 11'd1024}) begin
      n_fail++; $display("FAIL restart_final got %b want 0/1/1024", {busy0, done0, cnt0});
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_decim3();
    test_toggle();
    test_start_ignored();
    test_reset_mid();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
